aes_spi_frame_ctrl: RTL and testbench

//  Byte-level frame controller between the SPI slave and an AES cipher core (enc or dec).

---
 rtl/aes_spi_pkg.sv | 26 ++
 rtl/byte_shift_in.sv | 35 +++
 rtl/aes_spi_frame_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_aes_spi_frame_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the SPI-to-AES frame controller.
package aes_spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_KEY,
        S_DATA,
        S_RUN,
        S_SEND,
        S_ERR
    } state_t;

    localparam int unsigned HDR_MODE_BIT = 7;
    localparam int unsigned HDR_KEEP_BIT = 6;
    localparam int unsigned HDR_NK_MSB   = 3;

    localparam logic [7:0] ST_BUSY = 8'h00;
    localparam logic [7:0] ST_ERR  = 8'hEE;

    // NK must be an AES key length the instantiated core width can hold
    function automatic logic nk_legal(input logic [3:0] nk, input int unsigned max_nk);
        return ((nk == 4'd4) || (nk == 4'd6) || (nk == 4'd8)) && (32'(nk) <= max_nk);
    endfunction

endpackage

// File: rtl/byte_shift_in.sv
// MSB-first byte collector: byte k lands in the k-th byte from the top, so a
// partial fill is already left-aligned. full compares the count with a runtime limit.
module byte_shift_in #(
    parameter int unsigned NBYTES = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  shift,
    input  logic [7:0]            din,
    input  logic [CNT_W-1:0]      limit,
    output logic [8*NBYTES-1:0]   data,
    output logic [CNT_W-1:0]      count,
    output logic                  full
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data  <= '0;
            count <= '0;
        end else if (clr) begin
            data  <= '0;
            count <= '0;
        end else if (shift) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (count == CNT_W'(i)) data[8*(NBYTES-i)-1 -: 8] <= din;
            end
            count <= count + CNT_W'(1);
        end
    end

    assign full = (count == limit);

endmodule

// File: rtl/aes_spi_frame_ctrl.sv
// Byte-level frame controller between an SPI slave and an AES core:
// header, optional key, block data, core run with timeout, result readback.
module aes_spi_frame_ctrl
    import aes_spi_pkg::*;
#(
    parameter int unsigned DATA_BYTES  = 16,
    parameter int unsigned MAX_NK      = 8,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cs,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    core_start,
    output logic                    core_decrypt,
    output logic [3:0]              core_nk,
    output logic [32*MAX_NK-1:0]    core_key,
    output logic [8*DATA_BYTES-1:0] core_data_in,
    input  logic                    core_done,
    input  logic [8*DATA_BYTES-1:0] core_data_out,
    output logic                    done,
    output logic                    busy,
    output logic                    frame_err,
    output logic                    key_valid
);

    localparam int unsigned KEY_BYTES = 4 * MAX_NK;
    localparam int unsigned CNT_MAX   = (KEY_BYTES > DATA_BYTES) ? KEY_BYTES : DATA_BYTES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BLK_W     = 8 * DATA_BYTES;

    state_t state, state_next;

    logic                  cs_q;
    logic [BLK_W-1:0]      out_reg, out_next;
    logic [CNT_W-1:0]      send_cnt, send_cnt_next;
    logic [TMO_W-1:0]      tmo_cnt, tmo_next;
    logic [7:0]            tx_d;
    logic                  core_start_d, core_decrypt_d, done_d, busy_d, frame_err_d, key_valid_d;
    logic [3:0]            core_nk_d;

    logic                  key_clr, key_shift, key_full;
    logic                  data_clr, data_shift, data_full;
    logic [CNT_W-1:0]      key_cnt, data_cnt;

    byte_shift_in #(.NBYTES(KEY_BYTES), .CNT_W(CNT_W)) u_key (
        .clk   (clk),
        .reset (reset),
        .clr   (key_clr),
        .shift (key_shift),
        .din   (rx_data),
        .limit (CNT_W'({core_nk, 2'b00})),
        .data  (core_key),
        .count (key_cnt),
        .full  (key_full)
    );

    byte_shift_in #(.NBYTES(DATA_BYTES), .CNT_W(CNT_W)) u_data (
        .clk   (clk),
        .reset (reset),
        .clr   (data_clr),
        .shift (data_shift),
        .din   (rx_data),
        .limit (CNT_W'(DATA_BYTES)),
        .data  (core_data_in),
        .count (data_cnt),
        .full  (data_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next state plus next value of every registered output
    always_comb begin
        state_next     = state;
        key_clr        = 1'b0;
        key_shift      = 1'b0;
        data_clr       = 1'b0;
        data_shift     = 1'b0;
        core_start_d   = 1'b0;
        done_d         = 1'b0;
        core_decrypt_d = core_decrypt;
        core_nk_d      = core_nk;
        key_valid_d    = key_valid;
        frame_err_d    = frame_err;
        out_next       = out_reg;
        send_cnt_next  = send_cnt;
        tmo_next       = tmo_cnt;

        if (cs_q && !cs) frame_err_d = 1'b0;

        // A raised chip select aborts the frame and swallows any same-cycle byte
        if (state != S_IDLE && cs) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (!cs) state_next = S_HDR;
                S_HDR: if (rx_valid) begin
                    if (!nk_legal(rx_data[HDR_NK_MSB:0], MAX_NK) ||
                        (rx_data[HDR_KEEP_BIT] && !key_valid)) begin
                        state_next = S_ERR;
                    end else begin
                        core_decrypt_d = rx_data[HDR_MODE_BIT];
                        data_clr       = 1'b1;
                        if (rx_data[HDR_KEEP_BIT]) begin
                            state_next = S_DATA;
                        end else begin
                            state_next  = S_KEY;
                            core_nk_d   = rx_data[HDR_NK_MSB:0];
                            key_clr     = 1'b1;
                            key_valid_d = 1'b0;
                        end
                    end
                end
                S_KEY: begin
                    if (key_full) begin
                        state_next  = S_DATA;
                        key_valid_d = 1'b1;
                    end else if (rx_valid && key_cnt < CNT_W'(KEY_BYTES)) begin
                        key_shift = 1'b1;
                    end
                end
                S_DATA: begin
                    if (data_full) begin
                        state_next   = S_RUN;
                        core_start_d = 1'b1;
                        tmo_next     = '0;
                    end else if (rx_valid && data_cnt < CNT_W'(DATA_BYTES)) begin
                        data_shift = 1'b1;
                    end
                end
                S_RUN: begin
                    if (core_done) begin
                        state_next    = S_SEND;
                        out_next      = core_data_out;
                        send_cnt_next = '0;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                        state_next = S_ERR;
                    end else begin
                        tmo_next = tmo_cnt + TMO_W'(1);
                    end
                end
                S_SEND: if (rx_valid) begin
                    out_next = {out_reg[BLK_W-9:0], 8'h00};
                    if (send_cnt == CNT_W'(DATA_BYTES - 1)) begin
                        state_next = S_IDLE;
                        done_d     = 1'b1;
                    end else begin
                        send_cnt_next = send_cnt + CNT_W'(1);
                    end
                end
                S_ERR:   state_next = S_ERR;
                default: state_next = S_IDLE;
            endcase
        end

        if (state_next == S_ERR) frame_err_d = 1'b1;

        case (state_next)
            S_SEND:  tx_d = out_next[BLK_W-1 -: 8];
            S_ERR:   tx_d = ST_ERR;
            default: tx_d = ST_BUSY;
        endcase
        busy_d = (state_next != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q         <= 1'b0;
            out_reg      <= '0;
            send_cnt     <= '0;
            tmo_cnt      <= '0;
            tx_data      <= 8'h00;
            core_start   <= 1'b0;
            core_decrypt <= 1'b0;
            core_nk      <= 4'd0;
            done         <= 1'b0;
            busy         <= 1'b0;
            frame_err    <= 1'b0;
            key_valid    <= 1'b0;
        end else begin
            cs_q         <= cs;
            out_reg      <= out_next;
            send_cnt     <= send_cnt_next;
            tmo_cnt      <= tmo_next;
            tx_data      <= tx_d;
            core_start   <= core_start_d;
            core_decrypt <= core_decrypt_d;
            core_nk      <= core_nk_d;
            done         <= done_d;
            busy         <= busy_d;
            frame_err    <= frame_err_d;
            key_valid    <= key_valid_d;
        end
    end

endmodule

// File: tb/tb_aes_spi_frame_ctrl.sv
// Scoreboard bench for aes_spi_frame_ctrl: stimulus queues expected core
// launches, tx bytes and done pulses; a negedge monitor pops and compares.
module tb_aes_spi_frame_ctrl;

    localparam int unsigned TIMEOUT_CYC = 1023;

    localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] D1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] D3   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] R1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] R2   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] R3   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk, reset, cs, rx_valid, core_done;
    logic [7:0]   rx_data, tx_data;
    logic         core_start, core_decrypt, done, busy, frame_err, key_valid;
    logic [3:0]   core_nk;
    logic [255:0] core_key;
    logic [127:0] core_data_in, core_data_out;

    typedef struct packed {
        logic [255:0] key;
        logic [127:0] data;
        logic         dec;
        logic [3:0]   nk;
    } start_t;

    start_t     start_q[$];
    logic [7:0] tx_q[$];
    bit         done_q[$];

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit rd_phase = 1'b0;

    aes_spi_frame_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .cs            (cs),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .core_start    (core_start),
        .core_decrypt  (core_decrypt),
        .core_nk       (core_nk),
        .core_key      (core_key),
        .core_data_in  (core_data_in),
        .core_done     (core_done),
        .core_data_out (core_data_out),
        .done          (done),
        .busy          (busy),
        .frame_err     (frame_err),
        .key_valid     (key_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every core launch, read-phase tx byte and done pulse
    always @(negedge clk) begin : mon
        start_t e;
        logic [7:0] b;
        if (!reset) begin
            if (core_start) begin
                start_cnt++;
                start_cyc = cyc;
                chk("start_expected", 256'(start_q.size() != 0), 256'd1);
                if (start_q.size() != 0) begin
                    e = start_q.pop_front();
                    chk("core_key", core_key, e.key);
                    chk("core_data_in", 256'(core_data_in), 256'(e.data));
                    chk("core_decrypt", 256'(core_decrypt), 256'(e.dec));
                    chk("core_nk", 256'(core_nk), 256'(e.nk));
                end
            end
            if (rx_valid && rd_phase) begin
                chk("tx_expected", 256'(tx_q.size() != 0), 256'd1);
                if (tx_q.size() != 0) begin
                    b = tx_q.pop_front();
                    chk("tx_byte", 256'(tx_data), 256'(b));
                end
            end
            if (done) begin
                chk("done_expected", 256'(done_q.size() != 0), 256'd1);
                if (done_q.size() != 0) void'(done_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic open_frame();
        cs = 1'b0;
        tick();
        tick();
    endtask

    task automatic close_frame();
        cs = 1'b1;
        tick();
        tick();
    endtask

    task automatic send_frame(input logic [7:0] hdr, input int nkey,
                              input logic [255:0] key_l, input logic [127:0] data);
        xfer(hdr);
        for (int i = 0; i < nkey; i++) xfer(key_l[255-8*i -: 8]);
        for (int i = 0; i < 16; i++)   xfer(data[127-8*i -: 8]);
    endtask

    task automatic wait_start(input int prev, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (start_cnt != prev) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic core_reply(input logic [127:0] res);
        tick();
        tick();
        core_data_out = res;
        core_done     = 1'b1;
        tick();
        core_done     = 1'b0;
        tick();
    endtask

    task automatic read_back(input logic [127:0] res, input int n, input bit exp_done);
        for (int i = 0; i < n; i++) tx_q.push_back(res[127-8*i -: 8]);
        if (exp_done) done_q.push_back(1'b1);
        rd_phase = 1'b1;
        for (int i = 0; i < n; i++) xfer(8'hA5);
        rd_phase = 1'b0;
    endtask

    task automatic full_frame(input logic [7:0] hdr, input int nkey, input logic [255:0] key_l,
                              input logic [127:0] data, input logic [255:0] exp_key,
                              input logic exp_dec, input logic [3:0] exp_nk,
                              input logic [127:0] res);
        start_t e;
        int prev;
        bit seen;
        e.key = exp_key;
        e.data = data;
        e.dec = exp_dec;
        e.nk = exp_nk;
        start_q.push_back(e);
        open_frame();
        prev = start_cnt;
        send_frame(hdr, nkey, key_l, data);
        wait_start(prev, seen);
        chk("start_seen", 256'(seen), 256'd1);
        if (seen) begin
            core_reply(res);
            read_back(res, 16, 1'b1);
            chk("done_seen", 256'(done_q.size()), 256'd0);
        end
        close_frame();
    endtask

    initial begin : stim
        start_t e;
        int prev;
        int n;
        bit seen;
        reset = 1'b1;
        cs = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        core_done = 1'b0;
        core_data_out = '0;
        repeat (3) tick();
        chk("rst_tx", 256'(tx_data), 256'h00);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_key_valid", 256'(key_valid), 256'd0);
        chk("rst_frame_err", 256'(frame_err), 256'd0);
        chk("rst_core_key", core_key, 256'd0);
        reset = 1'b0;
        tick();
        tick();

        // NK=4 encrypt
        full_frame(8'h04, 16, {K128, 128'h0}, D1, {K128, 128'h0}, 1'b0, 4'd4, R1);
        chk("t1_key_valid", 256'(key_valid), 256'd1);
        chk("t1_busy_idle", 256'(busy), 256'd0);

        // Key reuse: no key bytes, stored NK=4 key unchanged
        full_frame(8'h44, 0, 256'h0, D3, {K128, 128'h0}, 1'b0, 4'd4, R3);

        // NK=8 decrypt with full 256-bit key
        full_frame(8'h88, 32, K256, D1, K256, 1'b1, 4'd8, R2);

        // Illegal NK -> sticky error, cleared by the next cs falling edge
        open_frame();
        xfer(8'h05);
        chk("t4_frame_err", 256'(frame_err), 256'd1);
        chk("t4_tx_err", 256'(tx_data), 256'hEE);
        chk("t4_key_kept", 256'(key_valid), 256'd1);
        cs = 1'b1;
        tick();
        tick();
        chk("t4_err_sticky", 256'(frame_err), 256'd1);
        chk("t4_idle", 256'(busy), 256'd0);
        cs = 1'b0;
        tick();
        chk("t4_err_clear", 256'(frame_err), 256'd0);
        chk("t4_hdr_busy", 256'(busy), 256'd1);
        chk("t4_tx_status", 256'(tx_data), 256'h00);
        close_frame();

        // Aborted key phase invalidates the stored key
        open_frame();
        xfer(8'h04);
        chk("t5_kv_cleared", 256'(key_valid), 256'd0);
        for (int i = 0; i < 10; i++) xfer(8'(i));
        cs = 1'b1;
        tick();
        chk("t5_abort_idle", 256'(busy), 256'd0);
        chk("t5_key_invalid", 256'(key_valid), 256'd0);
        tick();
        open_frame();
        xfer(8'h44);
        chk("t5_keep_err", 256'(frame_err), 256'd1);
        chk("t5_keep_tx", 256'(tx_data), 256'hEE);
        close_frame();

        // Core timeout; reserved header bits set
        e.key = {K128, 128'h0};
        e.data = D1;
        e.dec = 1'b0;
        e.nk = 4'd4;
        start_q.push_back(e);
        open_frame();
        prev = start_cnt;
        send_frame(8'h34, 16, {K128, 128'h0}, D1);
        wait_start(prev, seen);
        chk("t6_start_seen", 256'(seen), 256'd1);
        n = 0;
        while (!frame_err && n < 3000) begin
            tick();
            n++;
        end
        chk("t6_timeout_cycles", 256'(cyc - start_cyc), 256'(TIMEOUT_CYC));
        chk("t6_tx_err", 256'(tx_data), 256'hEE);
        core_reply(R1);
        chk("t6_done_in_err_ignored", 256'(tx_data), 256'hEE);
        close_frame();

        // Reset in the middle of the readback
        e.key = {K128, 128'h0};
        e.data = D3;
        e.dec = 1'b0;
        e.nk = 4'd4;
        start_q.push_back(e);
        open_frame();
        prev = start_cnt;
        send_frame(8'h44, 0, 256'h0, D3);
        wait_start(prev, seen);
        chk("t6b_start_seen", 256'(seen), 256'd1);
        core_reply(R3);
        read_back(R3, 5, 1'b0);
        chk("t6b_tx_mid_send", 256'(tx_data), 256'hDC);
        #2 reset = 1'b1;
        #1;
        chk("rst2_tx", 256'(tx_data), 256'h00);
        chk("rst2_busy", 256'(busy), 256'd0);
        chk("rst2_key_valid", 256'(key_valid), 256'd0);
        chk("rst2_core_key", core_key, 256'd0);
        chk("rst2_core_data_in", 256'(core_data_in), 256'd0);
        chk("rst2_core_nk", 256'(core_nk), 256'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cs = 1'b1;
        tick();

        chk("start_q_empty", 256'(start_q.size()), 256'd0);
        chk("tx_q_empty", 256'(tx_q.size()), 256'd0);
        chk("done_q_empty", 256'(done_q.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
